// File: rtl/tdc_frame_drain_if.sv
// Valid/ready word stream that carries a drained TDC frame (header, payload, trailer).
interface tdc_frame_drain_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/tdc_frame_drain.sv
// Snoops the TDC DPRAM write port, replays each frame as a word stream and answers the
// frame handshake. Define TDC_FRAME_DRAIN_CHECKSUM_EN to append an XOR checksum word.
module tdc_frame_drain #(
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 32,
  parameter logic [7:0] HEADER_TAG = 8'hA5
) (
  input  logic              SYSCLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] ram_data,
  input  logic [ADDR_W-1:0] ram_address,
  input  logic              ram_we,
  input  logic              handshakeFPGA,
  input  logic [DATA_W-1:0] hitCount,
  output logic              handshakePC,
  tdc_frame_drain_if.master m,
  output logic [14:0]       frame_seq,
  output logic              proto_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    TRAILER,
    CHECKSUM,
    ACK
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   hwm_q, hwm_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] hit_q, hit_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [14:0]       seq_q, seq_d;
  logic              err_q, err_d;
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
`endif

  logic [DATA_W-1:0] frame_mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W:0]   wr_end;
  logic [ADDR_W:0]   hwm_max;
  logic              ptr_last;
  logic              word_valid;
  logic              word_last;
  logic [DATA_W-1:0] word_data;
  logic              xfer;

  assign wr_end   = {1'b0, ram_address} + (ADDR_W+1)'(1);
  assign hwm_max  = (wr_end > hwm_q) ? wr_end : hwm_q;
  assign ptr_last = ({1'b0, ptr_q} == (count_q - (ADDR_W+1)'(1)));
  assign xfer     = word_valid && m.m_ready;

  assign m.m_valid = word_valid;
  assign m.m_last  = word_last;
  assign m.m_data  = word_data;
  assign frame_seq = seq_q;
  assign proto_err = err_q;

  // Buffer contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge SYSCLK) begin
    if (mem_we) begin
      frame_mem[ram_address] <= ram_data;
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      hwm_q   <= '0;
      count_q <= '0;
      hit_q   <= '0;
      ptr_q   <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hwm_q   <= hwm_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      ptr_q   <= ptr_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Stream outputs decode straight from registered state, so they hold while stalled.
  always_comb begin
    state_d     = state_q;
    hwm_d       = hwm_q;
    count_d     = count_q;
    hit_d       = hit_q;
    ptr_d       = ptr_q;
    seq_d       = seq_q;
    err_d       = err_q;
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    mem_we      = 1'b0;
    word_valid  = 1'b0;
    word_last   = 1'b0;
    word_data   = '0;
    handshakePC = 1'b0;

    case (state_q)
      IDLE: begin
        if (ram_we) begin
          mem_we = 1'b1;
          hwm_d  = hwm_max;
        end
        if (handshakeFPGA) begin
          count_d = ram_we ? hwm_max : hwm_q;
          hit_d   = hitCount;
          state_d = HEADER;
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      HEADER: begin
        word_valid = 1'b1;
        word_data  = {HEADER_TAG, seq_q, count_q};
        if (xfer) begin
          ptr_d   = '0;
          state_d = (count_q == '0) ? TRAILER : PAYLOAD;
        end
      end
      PAYLOAD: begin
        word_valid = 1'b1;
        word_data  = frame_mem[ptr_q];
        if (xfer) begin
          if (ptr_last) begin
            state_d = TRAILER;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      TRAILER: begin
        word_valid = 1'b1;
        word_data  = hit_q;
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
        if (xfer) begin
          state_d = CHECKSUM;
        end
`else
        word_last = 1'b1;
        if (xfer) begin
          state_d = ACK;
        end
`endif
      end
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
      CHECKSUM: begin
        word_valid = 1'b1;
        word_last  = 1'b1;
        word_data  = chk_q;
        if (xfer) begin
          state_d = ACK;
        end
      end
`endif
      ACK: begin
        handshakePC = 1'b1;
        if (!handshakeFPGA) begin
          state_d = IDLE;
          hwm_d   = '0;
          seq_d   = seq_q + 15'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
    // The trailer folds in at its own transfer, so the checksum is ready the next cycle.
    if (xfer) begin
      chk_d = chk_q ^ word_data;
    end
`endif

    if (ram_we && (state_q != IDLE)) begin
      err_d = 1'b1;
    end
    if (word_valid && !handshakeFPGA) begin
      err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_frame_drain.sv
// Directed bench for tdc_frame_drain: basic, stale, empty, full, backpressure,
// violation and reset frames, with checksum expectations when the macro is defined.
module tb_tdc_frame_drain;

  logic        SYSCLK;
  logic        RESET_N;
  logic [31:0] ram_data;
  logic [7:0]  ram_address;
  logic        ram_we;
  logic        handshakeFPGA;
  logic [31:0] hitCount;
  logic        handshakePC;
  logic [14:0] frame_seq;
  logic        proto_err;

  tdc_frame_drain_if #(.DATA_W(32)) sif ();

  tdc_frame_drain dut (
    .SYSCLK        (SYSCLK),
    .RESET_N       (RESET_N),
    .ram_data      (ram_data),
    .ram_address   (ram_address),
    .ram_we        (ram_we),
    .handshakeFPGA (handshakeFPGA),
    .hitCount      (hitCount),
    .handshakePC   (handshakePC),
    .m             (sif.master),
    .frame_seq     (frame_seq),
    .proto_err     (proto_err)
  );

  int          testsRun  = 0;
  int          failCount = 0;
  logic [31:0] expXor;

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [31:0] data,
                               input logic req, input logic [31:0] hc);
    ram_we        = we;
    ram_address   = addr;
    ram_data      = data;
    handshakeFPGA = req;
    hitCount      = hc;
  endtask

  task automatic writeWord(input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, hitCount);
    tick();
    ram_we = 1'b0;
  endtask

  task automatic request(input logic [31:0] hc);
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, hc);
    tick();
    expXor = 32'd0;
  endtask

  task automatic expectWord(input string tag, input logic [31:0] data, input logic last);
    sif.m_ready = 1'b1;
    checkOutput({tag, " valid"}, {31'd0, sif.m_valid}, 32'd1);
    checkOutput({tag, " data"}, sif.m_data, data);
    checkOutput({tag, " last"}, {31'd0, sif.m_last}, {31'd0, last});
    expXor = expXor ^ data;
    tick();
  endtask

  task automatic expectTail(input string tag, input logic [31:0] hc);
    logic [31:0] c;
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
    expectWord({tag, " trailer"}, hc, 1'b0);
    c = expXor;
    expectWord({tag, " checksum"}, c, 1'b1);
`else
    c = 32'd0;
    expectWord({tag, " trailer"}, hc, 1'b1);
`endif
  endtask

  task automatic expectAck(input string tag, input logic [14:0] seq);
    checkOutput({tag, " ack valid"}, {31'd0, sif.m_valid}, 32'd0);
    checkOutput({tag, " ack hsPC"}, {31'd0, handshakePC}, 32'd1);
    handshakeFPGA = 1'b0;
    tick();
    checkOutput({tag, " done hsPC"}, {31'd0, handshakePC}, 32'd0);
    checkOutput({tag, " seq"}, {17'd0, frame_seq}, {17'd0, seq});
  endtask

  logic [31:0] bpWords[$];
  logic        bpLast[$];
  int          bpIdx;
  logic        rdy;
  bit          heldHdr;
  bit          heldTrl;

  initial begin
    RESET_N     = 1'b0;
    sif.m_ready = 1'b0;
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 32'd0);
    #3;
    checkOutput("reset valid", {31'd0, sif.m_valid}, 32'd0);
    checkOutput("reset last", {31'd0, sif.m_last}, 32'd0);
    checkOutput("reset data", sif.m_data, 32'd0);
    checkOutput("reset hsPC", {31'd0, handshakePC}, 32'd0);
    checkOutput("reset seq", {17'd0, frame_seq}, 32'd0);
    checkOutput("reset err", {31'd0, proto_err}, 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();

    // Basic frame
    writeWord(8'd0, 32'h11);
    writeWord(8'd1, 32'h22);
    writeWord(8'd2, 32'h33);
    writeWord(8'd3, 32'h44);
    request(32'h7);
    expectWord("basic hdr", 32'hA5000004, 1'b0);
    expectWord("basic p0", 32'h11, 1'b0);
    expectWord("basic p1", 32'h22, 1'b0);
    expectWord("basic p2", 32'h33, 1'b0);
    expectWord("basic p3", 32'h44, 1'b0);
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
    expectWord("basic trailer", 32'h7, 1'b0);
    expectWord("basic checksum", 32'hA5000047, 1'b1);
`else
    expectWord("basic trailer", 32'h7, 1'b1);
`endif
    expectAck("basic", 15'd1);

    // Second frame: write lands in the same cycle as the request
    applyStimulus(1'b1, 8'd1, 32'hBEEF, 1'b1, 32'h12345678);
    tick();
    ram_we = 1'b0;
    expXor = 32'd0;
    expectWord("second hdr", 32'hA5000202, 1'b0);
    expectWord("second stale", 32'h11, 1'b0);
    expectWord("second p1", 32'hBEEF, 1'b0);
    expectTail("second", 32'h12345678);
    expectAck("second", 15'd2);

    // Empty frame
    request(32'h0000000A);
    expectWord("empty hdr", 32'hA5000400, 1'b0);
    expectTail("empty", 32'h0000000A);
    expectAck("empty", 15'd3);

    // Full frame
    for (int i = 0; i < 256; i++) begin
      writeWord(i[7:0], 32'hC0DE0000 | i);
    end
    request(32'h00000100);
    expectWord("full hdr", 32'hA5000700, 1'b0);
    for (int i = 0; i < 256; i++) begin
      expectWord($sformatf("full p%0d", i), 32'hC0DE0000 | i, 1'b0);
    end
    expectTail("full", 32'h00000100);
    expectAck("full", 15'd4);

    // Backpressure with random m_ready, forced low once on header and trailer
    writeWord(8'd0, 32'h0000B000);
    writeWord(8'd1, 32'h0000B001);
    writeWord(8'd2, 32'h0000B002);
    sif.m_ready = 1'b0;
    request(32'h00000BBB);
    bpWords = '{32'hA5000803, 32'h0000B000, 32'h0000B001, 32'h0000B002, 32'h00000BBB};
    bpLast  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef TDC_FRAME_DRAIN_CHECKSUM_EN
    bpLast[4] = 1'b0;
    bpWords.push_back(32'hA5000803 ^ 32'h0000B000 ^ 32'h0000B001 ^ 32'h0000B002 ^ 32'h00000BBB);
    bpLast.push_back(1'b1);
`endif
    bpIdx   = 0;
    heldHdr = 1'b0;
    heldTrl = 1'b0;
    for (int cyc = 0; cyc < 300 && bpIdx < bpWords.size(); cyc++) begin
      checkOutput($sformatf("bp valid w%0d", bpIdx), {31'd0, sif.m_valid}, 32'd1);
      checkOutput($sformatf("bp data w%0d", bpIdx), sif.m_data, bpWords[bpIdx]);
      checkOutput($sformatf("bp last w%0d", bpIdx), {31'd0, sif.m_last}, {31'd0, bpLast[bpIdx]});
      if (bpIdx == 0 && !heldHdr) begin
        rdy     = 1'b0;
        heldHdr = 1'b1;
      end else if (bpIdx == 4 && !heldTrl) begin
        rdy     = 1'b0;
        heldTrl = 1'b1;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      sif.m_ready = rdy;
      tick();
      if (rdy) bpIdx++;
    end
    checkOutput("bp words drained", bpIdx, bpWords.size());
    expectAck("bp", 15'd5);

    // Write during PAYLOAD is discarded and flagged
    writeWord(8'd0, 32'hAAAA0000);
    writeWord(8'd1, 32'hAAAA0001);
    request(32'h00000ABC);
    expectWord("viol hdr", 32'hA5000A02, 1'b0);
    sif.m_ready = 1'b0;
    applyStimulus(1'b1, 8'd1, 32'h0000DEAD, 1'b1, 32'h00000ABC);
    tick();
    ram_we = 1'b0;
    checkOutput("viol err", {31'd0, proto_err}, 32'd1);
    checkOutput("viol held", sif.m_data, 32'hAAAA0000);
    expectWord("viol p0", 32'hAAAA0000, 1'b0);
    expectWord("viol p1 unchanged", 32'hAAAA0001, 1'b0);
    expectTail("viol", 32'h00000ABC);
    expectAck("viol", 15'd6);

    // Reset asserted mid-PAYLOAD
    writeWord(8'd0, 32'hC0);
    writeWord(8'd1, 32'hC1);
    writeWord(8'd2, 32'hC2);
    request(32'h00000CCC);
    expectWord("rst hdr", 32'hA5000C03, 1'b0);
    checkOutput("rst in payload", {31'd0, sif.m_valid}, 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("rst valid", {31'd0, sif.m_valid}, 32'd0);
    checkOutput("rst hsPC", {31'd0, handshakePC}, 32'd0);
    checkOutput("rst seq", {17'd0, frame_seq}, 32'd0);
    checkOutput("rst err", {31'd0, proto_err}, 32'd0);
    handshakeFPGA = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();

    // Fresh hwm after reset; request dropped early still drains and flags
    writeWord(8'd0, 32'h55);
    writeWord(8'd1, 32'h66);
    request(32'h00000099);
    handshakeFPGA = 1'b0;
    expectWord("post hdr", 32'hA5000002, 1'b0);
    expectWord("post p0", 32'h55, 1'b0);
    expectWord("post p1", 32'h66, 1'b0);
    expectTail("post", 32'h00000099);
    checkOutput("early drop err", {31'd0, proto_err}, 32'd1);
    checkOutput("early drop hsPC", {31'd0, handshakePC}, 32'd1);
    tick();
    checkOutput("early drop done hsPC", {31'd0, handshakePC}, 32'd0);
    checkOutput("early drop seq", {17'd0, frame_seq}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
